// File: rtl/ultrasonic_proximity_encoder.sv
// HC-SR04-class ranger front end: fires periodic trigger pulses, times the echo
// and publishes a 4-bit proximity code (15 = nearest, 0 = far or no echo).
module ultrasonic_proximity_encoder #(
  parameter int TRIG_CYCLES    = 1000,
  parameter int TIMEOUT_CYCLES = 2500000,
  parameter int PERIOD_CYCLES  = 6000000,
  parameter int BIN_SHIFT      = 14,
  parameter int CNT_W          = 24
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enable,
  input  logic       echo,
  output logic       trig,
  output logic [3:0] prox_code,
  output logic       prox_valid,
  output logic       timeout_flag
);

  typedef enum logic [2:0] {
    IDLE,
    TRIG,
    WAIT_RISE,
    MEASURE,
    HOLDOFF
  } state_t;

  localparam logic [CNT_W-1:0] TRIG_LAST   = CNT_W'(TRIG_CYCLES - 1);
  localparam logic [CNT_W-1:0] TMO_LIMIT   = CNT_W'(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] PERIOD_LAST = CNT_W'(PERIOD_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);
  localparam logic [CNT_W-1:0] BIN_MAX     = CNT_W'(15);

  state_t           state;
  logic             echo_p0;
  logic             echo_p1;
  logic             echo_p2;
  logic [CNT_W-1:0] trig_cnt;
  logic [CNT_W-1:0] period_cnt;
  logic [CNT_W-1:0] tmo_cnt;
  logic [CNT_W-1:0] width_cnt;
  logic [CNT_W-1:0] tmo_next;
  logic             echo_s;
  logic             echo_rise;
  logic             tmo_hit;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] val);
    logic [CNT_W-1:0] res;
    if (val == '1) res = val;
    else           res = val + CNT_ONE;
    return res;
  endfunction

  // Wider echo means farther obstacle, so the bin is inverted into the code.
  function automatic logic [3:0] width_to_code(input logic [CNT_W-1:0] width);
    logic [CNT_W-1:0] bin;
    logic [3:0]       code;
    bin = width >> BIN_SHIFT;
    if (bin > BIN_MAX) code = 4'd0;
    else               code = 4'd15 - bin[3:0];
    return code;
  endfunction

  assign echo_s    = echo_p1;
  // A rise needs echo_s low the cycle before, so an echo already high on
  // entry to WAIT_RISE is ignored until it has been seen low.
  assign echo_rise = echo_p1 & ~echo_p2;
  assign tmo_next  = tmo_cnt + CNT_ONE;
  assign tmo_hit   = (tmo_next == TMO_LIMIT);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      echo_p0      <= 1'b0;
      echo_p1      <= 1'b0;
      echo_p2      <= 1'b0;
      trig_cnt     <= '0;
      period_cnt   <= '0;
      tmo_cnt      <= '0;
      width_cnt    <= '0;
      trig         <= 1'b0;
      prox_code    <= 4'd0;
      prox_valid   <= 1'b0;
      timeout_flag <= 1'b0;
    end else begin
      // p0/p1: two-flop synchronizer; p2: previous echo_s for edge detection
      echo_p0    <= echo;
      echo_p1    <= echo_p0;
      echo_p2    <= echo_p1;
      prox_valid <= 1'b0;
      if (state != IDLE) period_cnt <= period_cnt + CNT_ONE;

      case (state)
        IDLE: begin
          trig <= 1'b0;
          if (enable) begin
            state      <= TRIG;
            trig       <= 1'b1;
            trig_cnt   <= '0;
            period_cnt <= '0;
          end
        end

        TRIG: begin
          if (trig_cnt == TRIG_LAST) begin
            state     <= WAIT_RISE;
            trig      <= 1'b0;
            trig_cnt  <= '0;
            width_cnt <= '0;
            tmo_cnt   <= '0;
          end else begin
            trig_cnt <= trig_cnt + CNT_ONE;
          end
        end

        WAIT_RISE: begin
          tmo_cnt <= tmo_next;
          if (tmo_hit) begin
            state        <= HOLDOFF;
            prox_code    <= 4'd0;
            timeout_flag <= 1'b1;
            prox_valid   <= 1'b1;
          end else if (echo_rise) begin
            state     <= MEASURE;
            width_cnt <= CNT_ONE;
          end
        end

        MEASURE: begin
          tmo_cnt <= tmo_next;
          if (tmo_hit) begin
            state        <= HOLDOFF;
            prox_code    <= 4'd0;
            timeout_flag <= 1'b1;
            prox_valid   <= 1'b1;
          end else if (!echo_s) begin
            state        <= HOLDOFF;
            prox_code    <= width_to_code(width_cnt);
            timeout_flag <= 1'b0;
            prox_valid   <= 1'b1;
          end else begin
            width_cnt <= sat_inc(width_cnt);
          end
        end

        HOLDOFF: begin
          if (period_cnt == PERIOD_LAST) begin
            period_cnt <= '0;
            if (enable) begin
              state    <= TRIG;
              trig     <= 1'b1;
              trig_cnt <= '0;
            end else begin
              state <= IDLE;
            end
          end
        end

        default: begin
          state <= IDLE;
          trig  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/ultrasonic_proximity_encoder.md
Name: ultrasonic_proximity_encoder

Overview:
Drives an HC-SR04-class ultrasonic ranger and converts the echo pulse width into the 4-bit proximity code consumed by the obstacle-avoidance FSM. Larger codes mean a closer obstacle; the consumer flags an obstacle at code > 8. It sits between the sensor PMOD pins and the 4-bit proximity bus. It is the producer end of that bus and replaces the external microcontroller.

Parameters:
TRIG_CYCLES, 1000, trigger pulse high time in clk cycles (10 us at 100 MHz)
TIMEOUT_CYCLES, 2500000, maximum cycles from trigger end to echo fall before a timeout
PERIOD_CYCLES, 6000000, measurement repetition period in cycles, counted from trigger start
BIN_SHIFT, 14, right-shift applied to the echo width to form the distance bin
CNT_W, 24, width of every internal counter

Ports:
clk  input  1  system clock
reset  input  1  asynchronous, active-high reset
enable  input  1  level; 1 runs periodic measurements
echo  input  1  raw sensor echo, asynchronous to clk
trig  output  1  sensor trigger pulse
prox_code  output  4  latest proximity code; 15 = nearest, 0 = far or none
prox_valid  output  1  one-cycle pulse when prox_code updates
timeout_flag  output  1  1 if the last measurement timed out

Behaviour:
- Reset is asynchronous and active-high. Reset values: trig=0, prox_code=0, prox_valid=0, timeout_flag=0, state=IDLE, all counters 0, both synchronizer flops 0.
- echo passes through a 2-flop synchronizer to form echo_s. All logic uses echo_s only.
- State machine has states IDLE, TRIG, WAIT_RISE, MEASURE, HOLDOFF.
  - IDLE: trig=0. If enable=1, go to TRIG and clear the period counter.
  - TRIG: trig=1 for exactly TRIG_CYCLES cycles, then go to WAIT_RISE. On entry to WAIT_RISE, clear the width and timeout counters.
  - WAIT_RISE: wait for echo_s 0->1. An echo_s that is already high on entry is ignored until it is seen low first (the stuck-high guard). On the rising edge, go to MEASURE; that cycle counts as width=1.
  - MEASURE: width increments each cycle echo_s=1 and saturates at all ones. When echo_s=0 is seen, compute the code and go to HOLDOFF.
  - Timeout: the timeout counter increments every cycle in WAIT_RISE and MEASURE. When it reaches TIMEOUT_CYCLES, go to HOLDOFF with prox_code=0 and timeout_flag=1. This check has priority over an echo fall in the same cycle.
  - HOLDOFF: wait until the period counter equals PERIOD_CYCLES-1. Then go to TRIG if enable=1, else IDLE.
- The period counter increments every cycle from TRIG entry. It does not wrap before the HOLDOFF exit.
- Code computation (normal completion):
  - bin = width >> BIN_SHIFT, saturated to 15
  - prox_code = 15 - bin
  - timeout_flag = 0
- Latency: prox_code and prox_valid are registered 1 cycle after the cycle in which MEASURE sees echo_s=0, or 1 cycle after the timeout cycle.
- prox_valid is exactly one cycle wide, once per measurement.
- prox_code holds between updates and is never cleared by enable.
- enable deasserted mid-measurement: the current measurement completes and reports normally, then the FSM goes to IDLE at the end of HOLDOFF.
- enable asserted while in IDLE: trig rises on the next cycle.
- Reset mid-measurement: all outputs return to their reset values immediately, with no prox_valid pulse.
- Legal configuration requires PERIOD_CYCLES > TRIG_CYCLES + TIMEOUT_CYCLES + 4. Behaviour outside this is undefined.

Test Plan:
Use TRIG_CYCLES=10, TIMEOUT_CYCLES=2000, PERIOD_CYCLES=4000, BIN_SHIFT=6 for every scenario.
- enable=1 from reset -> trig high for exactly 10 cycles; the next trig rises exactly 4000 cycles after the first.
- Echo high 320 cycles after trigger -> bin 5, prox_code=10, timeout_flag=0, one prox_valid pulse at echo_s fall +1 cycle.
- Echo high 40 cycles -> prox_code=15. Echo high 1000 cycles -> prox_code=0 with timeout_flag=0. Echo high 575 cycles -> bin 8, prox_code=7.
- No echo -> prox_code=0, timeout_flag=1, prox_valid exactly 2000 cycles after WAIT_RISE entry.
- Echo stuck high from before trig -> rise ignored, timeout_flag=1. Echo high 2500 cycles -> timeout at 2000, prox_code=0.
- enable dropped during MEASURE -> code still reported, no further trig. Reset asserted mid-MEASURE -> trig=0, prox_code=0, no prox_valid pulse.
